// File: rtl/grant_bus_pkg.sv
// Shared encodings for the grant bus mux: arbiter grant codes, owner states and
// output source tags, plus the grant-to-owner decode used by the mux FSM.
package grant_bus_pkg;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_A    = 2'b10;
   localparam logic [1:0] GNT_B    = 2'b01;
   localparam logic [1:0] GNT_ILL  = 2'b11;

   localparam logic SRC_A = 1'b1;
   localparam logic SRC_B = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } owner_e;

   // Both "no grant" and the illegal code leave the bus unowned.
   function automatic owner_e decode_grant(input logic [1:0] grant);
      owner_e owner;
      case (grant)
         GNT_A:   owner = OWN_A;
         GNT_B:   owner = OWN_B;
         default: owner = IDLE;
      endcase
      return owner;
   endfunction

endpackage

// File: rtl/grant_bus_mux_if.sv
// Bundle of the arbiter grant, both requester beat ports and the shared output
// port. The mux takes the slave side; whoever drives grant and requesters takes master.
interface grant_bus_mux_if #(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
);
   import grant_bus_pkg::*;

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   logic [1:0]        grant;
   logic              a_valid;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;
   logic              b_valid;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_src;
   logic              out_ready;
   logic              a_release;
   logic              b_release;
   logic [CNT_W-1:0]  beat_count;
   logic              grant_err;

   modport slave (
      input  grant, a_valid, a_data, b_valid, b_data, out_ready,
      output a_ready, b_ready, out_valid, out_data, out_src,
             a_release, b_release, beat_count, grant_err
   );

   modport master (
      output grant, a_valid, a_data, b_valid, b_data, out_ready,
      input  a_ready, b_ready, out_valid, out_data, out_src,
             a_release, b_release, beat_count, grant_err
   );

endinterface

// File: rtl/grant_bus_mux_out_reg.sv
// One-entry valid/ready holding stage for the shared output port. A load and a
// drain in the same cycle keep the stage full, so the port runs at one beat per cycle.
module gbm_out_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              load_src,
   input  logic [DATA_W-1:0] load_data,
   input  logic              drain,
   output logic              out_valid,
   output logic              out_src,
   output logic [DATA_W-1:0] out_data
);

   logic            valid_q, valid_d;
   logic [DATA_W:0] payload_q, payload_d;

   always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      if (load) begin
         valid_d   = 1'b1;
         payload_d = {load_src, load_data};
      end else if (drain) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
      end
   end

   assign out_valid = valid_q;
   assign out_src   = payload_q[DATA_W];
   assign out_data  = payload_q[DATA_W-1:0];

endmodule

// File: rtl/grant_bus_mux.sv
// Routes the granted requester's beats onto the shared output port, counts beats per
// grant tenure and flags illegal grants. Define GBM_BURST_LIMIT_EN to cap tenures at MAX_BURST beats.
module grant_bus_mux
   import grant_bus_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input logic             clock,
   input logic             reset,
   grant_bus_mux_if.slave  bus
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   owner_e            state_q, state_d;
   logic [CNT_W-1:0]  beat_count_q, beat_count_d;
   logic              grant_err_q, grant_err_d;

   logic              new_tenure;
   logic              space;
   logic              limit;
   logic              a_ready, b_ready;
   logic              a_accept, b_accept, accept;
   logic              load_src;
   logic [DATA_W-1:0] load_data;
   logic              out_valid, out_src;
   logic [DATA_W-1:0] out_data;

   always_comb begin
      state_d    = decode_grant(bus.grant);
      new_tenure = (state_d != state_q);
   end

`ifdef GBM_BURST_LIMIT_EN
   localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST);
   // The count still belongs to the previous tenure on a switch cycle, so it must
   // not block the incoming owner.
   assign limit = !new_tenure && (beat_count_q == BURST_CAP);
`else
   assign limit = 1'b0;
`endif

   always_comb begin
      space    = !out_valid || bus.out_ready;
      a_ready  = !reset && (bus.grant == GNT_A) && space && !limit;
      b_ready  = !reset && (bus.grant == GNT_B) && space && !limit;
      a_accept = bus.a_valid && a_ready;
      b_accept = bus.b_valid && b_ready;
      accept   = a_accept || b_accept;
      load_src  = a_accept ? SRC_A : SRC_B;
      load_data = a_accept ? bus.a_data : bus.b_data;
   end

   always_comb begin
      beat_count_d = beat_count_q;
      if (new_tenure) begin
         beat_count_d = accept ? CNT_W'(1) : '0;
      end else if (accept && (beat_count_q != CNT_SAT)) begin
         beat_count_d = beat_count_q + CNT_W'(1);
      end
      grant_err_d = grant_err_q || (bus.grant == GNT_ILL);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         beat_count_q <= '0;
         grant_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_count_q <= beat_count_d;
         grant_err_q  <= grant_err_d;
      end
   end

   gbm_out_reg #(
      .DATA_W (DATA_W)
   ) u_out_reg (
      .clock     (clock),
      .reset     (reset),
      .load      (accept),
      .load_src  (load_src),
      .load_data (load_data),
      .drain     (bus.out_ready),
      .out_valid (out_valid),
      .out_src   (out_src),
      .out_data  (out_data)
   );

   assign bus.a_ready    = a_ready;
   assign bus.b_ready    = b_ready;
   assign bus.a_release  = limit && (bus.grant == GNT_A);
   assign bus.b_release  = limit && (bus.grant == GNT_B);
   assign bus.out_valid  = out_valid;
   assign bus.out_src    = out_src;
   assign bus.out_data   = out_data;
   assign bus.beat_count = beat_count_q;
   assign bus.grant_err  = grant_err_q;

endmodule

// File: tb/tb_grant_bus_mux.sv
// Self-checking bench for grant_bus_mux: a hand-computed vector table, then directed
// burst and randomized traffic checked against a queue-based reference model.
module tb_grant_bus_mux;

   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 4;
   localparam int CNT_W     = $clog2(MAX_BURST + 1);
   localparam int CNT_SAT   = (1 << CNT_W) - 1;
`ifdef GBM_BURST_LIMIT_EN
   localparam bit LIM_EN = 1'b1;
`else
   localparam bit LIM_EN = 1'b0;
`endif

   typedef struct {
      logic       rst;
      logic [1:0] gnt;
      logic       av;
      logic [7:0] ad;
      logic       bv;
      logic [7:0] bd;
      logic       ordy;
   } stim_t;

   typedef struct {
      logic       rst;
      logic [1:0] gnt;
      logic       av;
      logic [7:0] ad;
      logic       bv;
      logic [7:0] bd;
      logic       ordy;
      logic       e_ar;
      logic       e_br;
      logic       e_ov;
      logic       chk_d;
      logic [7:0] e_od;
      logic       e_src;
      logic [2:0] e_cnt;
      logic       e_err;
   } vec_t;

   typedef struct {
      logic       src;
      logic [7:0] data;
   } beat_t;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   // Reference model: owner 0=none 1=A 2=B, beats held in a queue of depth <= 1.
   int    m_owner = 0;
   int    m_count = 0;
   bit    m_err   = 1'b0;
   beat_t m_held[$];
   int    acc_a_cnt = 0;

   always #5 clock = ~clock;

   grant_bus_mux_if #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) bus ();

   grant_bus_mux #(
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic applyStimulus(input stim_t s);
      reset         = s.rst;
      bus.grant     = s.gnt;
      bus.a_valid   = s.av;
      bus.a_data    = s.ad;
      bus.b_valid   = s.bv;
      bus.b_data    = s.bd;
      bus.out_ready = s.ordy;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle, compare against the model, then advance the model across the edge.
   task automatic runModelCycle(input stim_t s, input string tag);
      int  owner_new;
      bit  new_ten, space, lim, e_ar, e_br, acc_a, acc_b;
      beat_t nb;
      @(negedge clock);
      applyStimulus(s);
      #1;
      owner_new = (s.gnt == 2'b10) ? 1 : (s.gnt == 2'b01) ? 2 : 0;
      new_ten   = (owner_new != m_owner);
      space     = (m_held.size() == 0) || s.ordy;
      lim       = LIM_EN && !new_ten && (m_count == MAX_BURST);
      e_ar      = !s.rst && (s.gnt == 2'b10) && space && !lim;
      e_br      = !s.rst && (s.gnt == 2'b01) && space && !lim;
      checkOutput({tag, " a_ready"}, 32'(bus.a_ready), 32'(e_ar));
      checkOutput({tag, " b_ready"}, 32'(bus.b_ready), 32'(e_br));
      checkOutput({tag, " a_release"}, 32'(bus.a_release), 32'(lim && s.gnt == 2'b10));
      checkOutput({tag, " b_release"}, 32'(bus.b_release), 32'(lim && s.gnt == 2'b01));
      checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'(m_held.size() != 0));
      if (m_held.size() != 0) begin
         checkOutput({tag, " out_data"}, 32'(bus.out_data), 32'(m_held[0].data));
         checkOutput({tag, " out_src"}, 32'(bus.out_src), 32'(m_held[0].src));
      end
      checkOutput({tag, " beat_count"}, 32'(bus.beat_count), 32'(m_count));
      checkOutput({tag, " grant_err"}, 32'(bus.grant_err), 32'(m_err));
      acc_a = s.av && e_ar;
      acc_b = s.bv && e_br;
      if (acc_a) acc_a_cnt++;
      if (s.rst) begin
         m_held.delete();
         m_owner = 0;
         m_count = 0;
         m_err   = 1'b0;
      end else begin
         if (m_held.size() != 0 && s.ordy) void'(m_held.pop_front());
         if (acc_a || acc_b) begin
            nb.src  = acc_a;
            nb.data = acc_a ? s.ad : s.bd;
            m_held.push_back(nb);
         end
         if (new_ten)             m_count = (acc_a || acc_b) ? 1 : 0;
         else if (acc_a || acc_b) m_count = (m_count < CNT_SAT) ? m_count + 1 : CNT_SAT;
         if (s.gnt == 2'b11) m_err = 1'b1;
         m_owner = owner_new;
      end
   endtask

   vec_t  tbl[19];
   stim_t st;

   initial begin
      tbl[0]  = '{1'b1, 2'b10, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
      tbl[1]  = '{1'b0, 2'b10, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
      tbl[2]  = '{1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 3'd1, 1'b0};
      tbl[3]  = '{1'b0, 2'b01, 1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
      tbl[4]  = '{1'b0, 2'b01, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 3'd1, 1'b0};
      tbl[5]  = '{1'b0, 2'b01, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 3'd1, 1'b0};
      tbl[6]  = '{1'b0, 2'b01, 1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 3'd1, 1'b0};
      tbl[7]  = '{1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 3'd2, 1'b0};
      tbl[8]  = '{1'b0, 2'b10, 1'b1, 8'h01, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0};
      tbl[9]  = '{1'b0, 2'b10, 1'b1, 8'h02, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 3'd1, 1'b0};
      tbl[10] = '{1'b0, 2'b00, 1'b1, 8'h02, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 3'd2, 1'b0};
      tbl[11] = '{1'b0, 2'b01, 1'b1, 8'h02, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
      tbl[12] = '{1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 3'd1, 1'b0};
      tbl[13] = '{1'b0, 2'b11, 1'b1, 8'h44, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0};
      tbl[14] = '{1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1};
      tbl[15] = '{1'b0, 2'b10, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1};
      tbl[16] = '{1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 3'd1, 1'b1};
      tbl[17] = '{1'b1, 2'b10, 1'b1, 8'h88, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 3'd0, 1'b1};
      tbl[18] = '{1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};

      st = '{1'b1, 2'b10, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1};
      applyStimulus(st);
      @(posedge clock);

      for (int i = 0; i < 19; i++) begin
         string tag;
         tag = $sformatf("row%0d", i);
         @(negedge clock);
         st = '{tbl[i].rst, tbl[i].gnt, tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].ordy};
         applyStimulus(st);
         #1;
         checkOutput({tag, " a_ready"}, 32'(bus.a_ready), 32'(tbl[i].e_ar));
         checkOutput({tag, " b_ready"}, 32'(bus.b_ready), 32'(tbl[i].e_br));
         checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'(tbl[i].e_ov));
         if (tbl[i].chk_d) begin
            checkOutput({tag, " out_data"}, 32'(bus.out_data), 32'(tbl[i].e_od));
            checkOutput({tag, " out_src"}, 32'(bus.out_src), 32'(tbl[i].e_src));
         end
         checkOutput({tag, " beat_count"}, 32'(bus.beat_count), 32'(tbl[i].e_cnt));
         checkOutput({tag, " grant_err"}, 32'(bus.grant_err), 32'(tbl[i].e_err));
      end

      // Long tenure for A: capped at MAX_BURST beats only when the limit is built in.
      for (int i = 0; i < 2; i++) runModelCycle('{1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1}, "burst_rst");
      acc_a_cnt = 0;
      for (int i = 0; i < 8; i++) runModelCycle('{1'b0, 2'b10, 1'b1, 8'(8'hA0 + i), 1'b0, 8'h00, 1'b1}, "burst_a");
      checkOutput("burst_accepts", 32'(acc_a_cnt), LIM_EN ? 32'(MAX_BURST) : 32'd8);
      for (int i = 0; i < 3; i++) runModelCycle('{1'b0, 2'b01, 1'b1, 8'h00, 1'b1, 8'(8'hB0 + i), 1'b1}, "switch_b");
      runModelCycle('{1'b0, 2'b00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1}, "burst_end");

      for (int i = 0; i < 600; i++) begin
         int g;
         g = int'($urandom_range(0, 19));
         st.rst  = ($urandom_range(0, 39) == 0);
         st.gnt  = (g < 9) ? 2'b10 : (g < 17) ? 2'b01 : (g < 19) ? 2'b00 : 2'b11;
         st.av   = ($urandom_range(0, 3) != 0);
         st.ad   = 8'($urandom);
         st.bv   = ($urandom_range(0, 3) != 0);
         st.bd   = 8'($urandom);
         st.ordy = ($urandom_range(0, 3) != 0);
         runModelCycle(st, $sformatf("rand%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
